// File: rtl/mips32_prog_loader_if.sv
// Program-image stream: 32-bit words with a valid/ready handshake into the loader.
// Latency: none (wires only).
// Backpressure: a word transfers only on a cycle where in_valid and in_ready are both 1.
//   master: stream source (drives in_data/in_valid, observes in_ready)
//   slave : loader        (observes in_data/in_valid, drives in_ready)
interface mips32_prog_loader_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mips32_prog_loader.sv
// Boot loader for pipe_MIPS32: writes a header+payload+checksum stream into core memory, then runs the core to HLT.
// Latency: each payload word is written exactly 1 cycle after its handshake; core_start pulses the cycle after the checksum is accepted.
// Backpressure: in_ready is 1 only while expecting header, payload or checksum; it is 0 in GO/RUN/DONE/ERR and for the first cycle after reset.
// Ports:
//   clk1, reset            - system clock, synchronous active-high reset
//   in_if (slave)          - program word stream (in_data/in_valid/in_ready)
//   mem_we/mem_addr/wdata  - registered write port into core instruction/data memory
//   core_hold/core_start   - core freeze and one-cycle start pulse; start_pc is the entry address (header base)
//   core_halted            - core HALTED flag
//   done/error             - sticky completion / rejection flags
//   words_loaded           - payload words written so far
module mips32_prog_loader #(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic                   clk1,
    input  logic                   reset,
    mips32_prog_loader_if.slave    in_if,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_wdata,
    output logic                   core_hold,
    output logic                   core_start,
    output logic [ADDR_W-1:0]      start_pc,
    input  logic                   core_halted,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_W:0]        words_loaded
);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_CHK,
        S_GO,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] LP_DEPTH17 = 17'(MEM_DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [ADDR_W-1:0]   r_start_pc;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_n;
    logic [ADDR_W:0]     r_cnt;
    logic [31:0]         r_acc;

    logic                w_xfer;
    logic                w_last;
    logic                w_hdr_ok;
    logic                w_base_hi_zero;
    logic [16:0]         w_hdr_end;
    logic [ADDR_W-1:0]   w_hdr_base;

    assign w_xfer = in_if.in_valid & r_in_ready;

    // Header: base in [31:16], count in [15:0]. Only the low ADDR_W base bits
    // address memory; any higher base bit set rejects the image. The end
    // address is formed 17 bits wide so a large count can never wrap.
    assign w_hdr_base     = in_if.in_data[16 +: ADDR_W];
    assign w_base_hi_zero = (in_if.in_data[31:16+ADDR_W] == '0);
    assign w_hdr_end      = 17'(w_hdr_base) + 17'(in_if.in_data[15:0]);
    assign w_hdr_ok       = (in_if.in_data[15:0] != 16'd0) && w_base_hi_zero
                            && (w_hdr_end <= LP_DEPTH17);

    assign w_last = ((r_cnt + (ADDR_W+1)'(1)) == r_n);

    // State register
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_next     = r_state;
        core_start = 1'b0;
        core_hold  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_xfer) begin
                    w_next = w_hdr_ok ? S_LOAD : S_ERR;
                end
            end
            S_LOAD: begin
                if (w_xfer && w_last) begin
                    w_next = S_CHK;
                end
            end
            S_CHK: begin
                if (w_xfer) begin
                    w_next = (in_if.in_data == r_acc) ? S_GO : S_ERR;
                end
            end
            S_GO: begin
                // core_halted is deliberately not looked at here: the core's
                // flag is still stale until it has seen the start pulse.
                core_start = 1'b1;
                core_hold  = 1'b0;
                w_next     = S_RUN;
            end
            S_RUN: begin
                core_hold = 1'b0;
                if (core_halted) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            S_ERR: begin
                error = 1'b1;
            end
            default: begin
                w_next = S_HDR;
            end
        endcase
    end

    // Datapath: handshake readiness, header latch, payload write and checksum.
    // in_ready is registered from the next state so it is low for the first
    // cycle out of reset and drops in the same cycle the FSM leaves CHK.
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_start_pc  <= '0;
            r_base      <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
        end else begin
            r_in_ready <= (w_next == S_HDR) || (w_next == S_LOAD) || (w_next == S_CHK);
            r_mem_we   <= 1'b0;
            case (r_state)
                S_HDR: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    if (w_xfer && w_hdr_ok) begin
                        r_base     <= w_hdr_base;
                        r_start_pc <= w_hdr_base;
                        // A valid count is at most MEM_DEPTH, so ADDR_W+1 bits hold it.
                        r_n        <= in_if.in_data[ADDR_W:0];
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_base + r_cnt[ADDR_W-1:0];
                        r_mem_wdata <= in_if.in_data;
                        r_cnt       <= r_cnt + (ADDR_W+1)'(1);
                        r_acc       <= r_acc ^ in_if.in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_if.in_ready = r_in_ready;
    assign mem_we         = r_mem_we;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign start_pc       = r_start_pc;
    assign words_loaded   = r_cnt;

endmodule
